instr_fetch_unit: RTL and testbench

Owns the program counter and instruction register of the multicycle core. It sequences a read from synchronous instruction memory and latches the returned word. It decodes the fixed fields (`op`, `op_ext`, `rdest`/`branch_cond`, `rsrc`, `imm8`) that drive the main controller FSM. It sits directly upstream of the controller: the controller requests fetches and PC updates, and this block supplies the decoded instruction and a busy/valid handshake.

---
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction register and fetch sequencer for the multicycle core.
// Optional illegal-opcode detection is built when IFU_ILLEGAL_DET_EN is defined.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              pc_en,
    input  logic              pc_s,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              busy,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic [3:0]        op,
    output logic [3:0]        rdest,
    output logic [3:0]        branch_cond,
    output logic [3:0]        op_ext,
    output logic [3:0]        rsrc,
    output logic [7:0]        imm8
`ifdef IFU_ILLEGAL_DET_EN
    ,
    output logic              illegal_instr
`endif
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              busy_q, busy_d;
    logic              ir_valid_q, ir_valid_d;

`ifdef IFU_ILLEGAL_DET_EN
    logic illegal_q, illegal_d;

    // Legal opcodes; op 4 is legal only with op_ext a multiple of 4.
    function automatic logic word_illegal(input logic [15:0] w);
        logic legal;
        case (w[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD: legal = 1'b1;
            4'h4:    legal = (w[5:4] == 2'b00);
            default: legal = 1'b0;
        endcase
        return !legal;
    endfunction
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
`ifdef IFU_ILLEGAL_DET_EN
        illegal_d  = illegal_q;
`endif

        if (pc_en) begin
            pc_d = pc_s ? alu_result : jump_target;
        end

        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    addr_d  = pc_q;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d   = LAT_M1;
                state_d = (MEM_LAT > 1) ? S_WAIT : S_CAPTURE;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                ir_d    = mem_rdata;
`ifdef IFU_ILLEGAL_DET_EN
                illegal_d = word_illegal(mem_rdata);
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered off the next state so they line up with it.
        mem_rd_d   = (state_d == S_REQ);
        busy_d     = (state_d != S_IDLE);
        ir_valid_d = (state_d == S_CAPTURE);
        mem_addr_d = (state_d == S_IDLE) ? pc_d : addr_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= PC_RST;
            cnt_q      <= '0;
            pc_q       <= PC_RST;
            ir_q       <= '0;
            mem_addr_q <= PC_RST;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            ir_valid_q <= 1'b0;
`ifdef IFU_ILLEGAL_DET_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
            ir_valid_q <= ir_valid_d;
`ifdef IFU_ILLEGAL_DET_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign busy        = busy_q;
    assign ir_valid    = ir_valid_q;
    assign pc          = pc_q;
    assign ir          = ir_q;

    // Fixed instruction fields decoded straight from the IR
    assign op          = ir_q[15:12];
    assign rdest       = ir_q[11:8];
    assign branch_cond = ir_q[11:8];
    assign op_ext      = ir_q[7:4];
    assign rsrc        = ir_q[3:0];
    assign imm8        = ir_q[7:0];

`ifdef IFU_ILLEGAL_DET_EN
    assign illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed sequences, a field-decode vector table and a
// randomized run against a cycle-count reference model.
module tb_instr_fetch_unit;

    localparam int unsigned LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- DUT A: MEM_LAT=1, RESET_PC=0x0010 ----------------
    logic        rst_a, fs_a;
    logic [15:0] rdata_a, addr_a, pc_a, ir_a;
    logic        rd_a, busy_a, irv_a;
    logic [3:0]  op_a, rdest_a, bc_a, ext_a, rsrc_a;
    logic [7:0]  imm_a;
    logic [15:0] mem_a [0:255];
`ifdef IFU_ILLEGAL_DET_EN
    logic        ill_a;
`endif
    assign rdata_a = mem_a[addr_a[7:0]];

    instr_fetch_unit #(.ADDR_W(16), .MEM_LAT(1), .RESET_PC(16'h0010)) dut_a (
        .clk(clk), .reset(rst_a), .fetch_start(fs_a), .pc_en(1'b0), .pc_s(1'b0),
        .alu_result(16'h0000), .jump_target(16'h0000), .mem_rdata(rdata_a),
        .mem_addr(addr_a), .mem_rd(rd_a), .busy(busy_a), .ir_valid(irv_a),
        .pc(pc_a), .ir(ir_a), .op(op_a), .rdest(rdest_a), .branch_cond(bc_a),
        .op_ext(ext_a), .rsrc(rsrc_a), .imm8(imm_a)
`ifdef IFU_ILLEGAL_DET_EN
        , .illegal_instr(ill_a)
`endif
    );

    // ---------------- DUT B: MEM_LAT=3, RESET_PC=0 ----------------
    logic        rst_b, fs_b, pc_en_b, pc_s_b;
    logic [15:0] alu_b, jt_b, rdata_b, addr_b, pc_b, ir_b;
    logic        rd_b, busy_b, irv_b;
    logic [3:0]  op_b, rdest_b, bc_b, ext_b, rsrc_b;
    logic [7:0]  imm_b;
    logic [15:0] mem_b [0:65535];
`ifdef IFU_ILLEGAL_DET_EN
    logic        ill_b;
`endif
    assign rdata_b = mem_b[addr_b];

    instr_fetch_unit #(.ADDR_W(16), .MEM_LAT(LAT_B), .RESET_PC(0)) dut_b (
        .clk(clk), .reset(rst_b), .fetch_start(fs_b), .pc_en(pc_en_b), .pc_s(pc_s_b),
        .alu_result(alu_b), .jump_target(jt_b), .mem_rdata(rdata_b),
        .mem_addr(addr_b), .mem_rd(rd_b), .busy(busy_b), .ir_valid(irv_b),
        .pc(pc_b), .ir(ir_b), .op(op_b), .rdest(rdest_b), .branch_cond(bc_b),
        .op_ext(ext_b), .rsrc(rsrc_b), .imm8(imm_b)
`ifdef IFU_ILLEGAL_DET_EN
        , .illegal_instr(ill_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc_b(input logic [15:0] v);
        pc_en_b = 1'b1; pc_s_b = 1'b0; jt_b = v;
        tick();
        pc_en_b = 1'b0;
    endtask

    // Pulse fetch_start, wait (bounded) for ir_valid, return one cycle after capture.
    task automatic fetch_b(input string nm);
        int n;
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        n = 0;
        while (!irv_b && n < 8) begin
            tick();
            n++;
        end
        chk({nm, "_irv_seen"}, 32'(irv_b), 32'd1);
        tick();
    endtask

`ifdef IFU_ILLEGAL_DET_EN
    function automatic logic model_illegal(input logic [15:0] w);
        logic [3:0] o, e;
        o = w[15:12];
        e = w[7:4];
        if (o inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD}) return 1'b0;
        if (o == 4'h4 && (e inside {4'h0, 4'h4, 4'h8, 4'hC})) return 1'b0;
        return 1'b1;
    endfunction
`endif

    typedef struct {
        logic [15:0] tgt;
        logic [15:0] word;
        logic [3:0]  e_op, e_rd, e_ext, e_rs;
        logic [7:0]  e_imm;
    } vec_t;

    vec_t vecs [4];

    // Reference model state for the randomized run
    logic [15:0] m_pc, m_ir, m_faddr;
    int          m_left;
    logic        m_ill;

    initial begin
        vecs[0] = '{16'h0100, 16'h4C53, 4'h4, 4'hC, 4'h5, 4'h3, 8'h53};
        vecs[1] = '{16'h0101, 16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 8'hFF};
        vecs[2] = '{16'h1234, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00};
        vecs[3] = '{16'hFFFF, 16'hA5E7, 4'hA, 4'h5, 4'hE, 4'h7, 8'hE7};

        for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) mem_b[i] = 16'h0000;
        mem_a[16] = 16'h4C53;
        mem_b[0]  = 16'h1234;

        rst_a = 1'b0; fs_a = 1'b0;
        rst_b = 1'b0; fs_b = 1'b0; pc_en_b = 1'b0; pc_s_b = 1'b0;
        alu_b = 16'h0; jt_b = 16'h0;
        tick(); tick();
        rst_a = 1'b1; rst_b = 1'b1;

        // Reset state
        chk("a_rst_pc", 32'(pc_a), 32'h10);
        chk("a_rst_ir", 32'(ir_a), 32'h0);
        chk("a_rst_busy", 32'(busy_a), 32'h0);
        chk("a_rst_mem_rd", 32'(rd_a), 32'h0);
        chk("a_rst_irv", 32'(irv_a), 32'h0);
        chk("a_rst_mem_addr", 32'(addr_a), 32'h10);
        chk("b_rst_pc", 32'(pc_b), 32'h0);
`ifdef IFU_ILLEGAL_DET_EN
        chk("b_rst_ill", 32'(ill_b), 32'h0);
`endif

        // Test 1: MEM_LAT=1 fetch from the reset PC
        fs_a = 1'b1;
        tick();
        fs_a = 1'b0;
        chk("t1_c1_mem_rd", 32'(rd_a), 32'h1);
        chk("t1_c1_mem_addr", 32'(addr_a), 32'h10);
        chk("t1_c1_busy", 32'(busy_a), 32'h1);
        chk("t1_c1_irv", 32'(irv_a), 32'h0);
        tick();
        chk("t1_c2_irv", 32'(irv_a), 32'h1);
        chk("t1_c2_mem_rd", 32'(rd_a), 32'h0);
        tick();
        chk("t1_c3_irv", 32'(irv_a), 32'h0);
        chk("t1_c3_busy", 32'(busy_a), 32'h0);
        chk("t1_op", 32'(op_a), 32'h4);
        chk("t1_rdest", 32'(rdest_a), 32'hC);
        chk("t1_bcond", 32'(bc_a), 32'hC);
        chk("t1_op_ext", 32'(ext_a), 32'h5);
        chk("t1_rsrc", 32'(rsrc_a), 32'h3);
        chk("t1_imm8", 32'(imm_a), 32'h53);

        // Test 2: MEM_LAT=3, busy over cycles 1..4, ir_valid at cycle 4
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("t2_c%0d_busy", c), 32'(busy_b), 32'(c <= 4));
            chk($sformatf("t2_c%0d_irv", c), 32'(irv_b), 32'(c == 4));
            chk($sformatf("t2_c%0d_mem_rd", c), 32'(rd_b), 32'(c == 1));
            if (c < 5) tick();
        end
        chk("t2_ir", 32'(ir_b), 32'h1234);

        // Test 3: PC source select and following fetch address
        pc_en_b = 1'b1; pc_s_b = 1'b1; alu_b = 16'h0021; jt_b = 16'h0999;
        tick();
        chk("t3_pc_alu", 32'(pc_b), 32'h21);
        chk("t3_mem_addr_idle", 32'(addr_b), 32'h21);
        pc_s_b = 1'b0; alu_b = 16'h0555; jt_b = 16'h0300;
        tick();
        pc_en_b = 1'b0;
        chk("t3_pc_jump", 32'(pc_b), 32'h300);
        mem_b[16'h0300] = 16'hBEEF;
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        chk("t3_req_addr", 32'(addr_b), 32'h300);
        chk("t3_req_rd", 32'(rd_b), 32'h1);
        tick(); tick(); tick();
        chk("t3_irv", 32'(irv_b), 32'h1);
        tick();
        chk("t3_ir", 32'(ir_b), 32'hBEEF);

        // Test 4: pc_en and a second fetch_start during WAIT
        mem_b[16'h0005] = 16'h5A5A;
        mem_b[16'h0040] = 16'h0404;
        set_pc_b(16'h0005);
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        tick();
        pc_en_b = 1'b1; pc_s_b = 1'b0; jt_b = 16'h0040; fs_b = 1'b1;
        tick();
        pc_en_b = 1'b0; fs_b = 1'b0;
        chk("t4_pc_new", 32'(pc_b), 32'h40);
        chk("t4_addr_held", 32'(addr_b), 32'h5);
        chk("t4_busy", 32'(busy_b), 32'h1);
        tick();
        chk("t4_irv", 32'(irv_b), 32'h1);
        tick();
        chk("t4_ir", 32'(ir_b), 32'h5A5A);
        chk("t4_busy_done", 32'(busy_b), 32'h0);
        chk("t4_addr_pc", 32'(addr_b), 32'h40);
        tick();
        chk("t4_no_requeue_busy", 32'(busy_b), 32'h0);
        chk("t4_no_requeue_rd", 32'(rd_b), 32'h0);

        // Test 5: synchronous reset in WAIT aborts the fetch
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        tick();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("t5_busy", 32'(busy_b), 32'h0);
        chk("t5_ir", 32'(ir_b), 32'h0);
        chk("t5_pc", 32'(pc_b), 32'h0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t5_no_irv%0d", c), 32'(irv_b), 32'h0);
            tick();
        end

        // Table-driven field decode across PC targets
        for (int i = 0; i < 4; i++) begin
            mem_b[vecs[i].tgt] = vecs[i].word;
            set_pc_b(vecs[i].tgt);
            chk($sformatf("v%0d_pc", i), 32'(pc_b), 32'(vecs[i].tgt));
            fetch_b($sformatf("v%0d", i));
            chk($sformatf("v%0d_ir", i), 32'(ir_b), 32'(vecs[i].word));
            chk($sformatf("v%0d_op", i), 32'(op_b), 32'(vecs[i].e_op));
            chk($sformatf("v%0d_rdest", i), 32'(rdest_b), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_bcond", i), 32'(bc_b), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_op_ext", i), 32'(ext_b), 32'(vecs[i].e_ext));
            chk($sformatf("v%0d_rsrc", i), 32'(rsrc_b), 32'(vecs[i].e_rs));
            chk($sformatf("v%0d_imm8", i), 32'(imm_b), 32'(vecs[i].e_imm));
        end

`ifdef IFU_ILLEGAL_DET_EN
        // Test 6: illegal detection set on capture, cleared by a legal capture
        mem_b[16'h0700] = 16'h4A70;
        mem_b[16'h0701] = 16'h4A40;
        set_pc_b(16'h0700);
        fetch_b("t6a");
        chk("t6_ill_set", 32'(ill_b), 32'h1);
        set_pc_b(16'h0701);
        fetch_b("t6b");
        chk("t6_ill_clr", 32'(ill_b), 32'h0);
`endif

        // Randomized run against the reference model
        for (int i = 0; i < 256; i++) mem_b[i] = 16'($urandom);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        m_pc = 16'h0; m_ir = 16'h0; m_faddr = 16'h0; m_left = 0; m_ill = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            fs_b    = ($urandom_range(0, 2) == 0);
            pc_en_b = ($urandom_range(0, 3) == 0);
            pc_s_b  = 1'($urandom_range(0, 1));
            alu_b   = 16'($urandom_range(0, 255));
            jt_b    = 16'($urandom_range(0, 255));
            rst_b   = ($urandom_range(0, 59) != 0);
            if (!rst_b) begin
                m_pc = 16'h0; m_ir = 16'h0; m_left = 0; m_ill = 1'b0;
            end else begin
                if (m_left == 1) begin
                    m_ir = mem_b[m_faddr];
`ifdef IFU_ILLEGAL_DET_EN
                    m_ill = model_illegal(m_ir);
`endif
                end
                if (m_left > 0) m_left--;
                else if (fs_b) begin
                    m_left  = int'(LAT_B) + 1;
                    m_faddr = m_pc;
                end
                if (pc_en_b) m_pc = pc_s_b ? alu_b : jt_b;
            end
            tick();
            chk("r_busy", 32'(busy_b), 32'(m_left > 0));
            chk("r_mem_rd", 32'(rd_b), 32'(m_left == int'(LAT_B) + 1));
            chk("r_irv", 32'(irv_b), 32'(m_left == 1));
            chk("r_mem_addr", 32'(addr_b), 32'((m_left > 0) ? m_faddr : m_pc));
            chk("r_pc", 32'(pc_b), 32'(m_pc));
            chk("r_ir", 32'(ir_b), 32'(m_ir));
            chk("r_imm8", 32'(imm_b), 32'(m_ir[7:0]));
`ifdef IFU_ILLEGAL_DET_EN
            chk("r_ill", 32'(ill_b), 32'(m_ill));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
